// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter between I-cache and D-cache.
// The arbiter grants one requester at a time, in this priority order:
// D-cache store first, then D-cache fill, then I-cache fill.
// A block fill issues BLK_WORDS back-to-back word reads.
// Each returning word is tagged with its index within the block.
// A D-cache write-through store is a single one-cycle write.
// All memory-facing and cache-facing outputs decode from the state register,
// so the latched address and data registers need no reset.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic                         d_req,
    input  logic                         d_wr_req,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_rvalid,
    output logic                         i_fill,
    output logic                         d_fill,
    output logic                         fill_valid,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         i_done,
    output logic                         d_done
);

    localparam int LW = $clog2(BLK_WORDS);
    localparam int CW = LW + 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic               owner_d;
    logic [CW-1:0]      iss;
    logic [CW-1:0]      ret;
    logic [ADDR_W-1:0]  addr_lat;
    logic [DATA_W-1:0]  wdata_lat;
    logic               grant;
    logic               iss_open;

    // Clear the byte-in-block bits to get the block base address.
    function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
        return a & ~(ADDR_W'(2 * BLK_WORDS - 1));
    endfunction

    assign grant    = d_wr_req | d_req | i_req;
    assign iss_open = (iss < CW'(BLK_WORDS));

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: grant by priority in IDLE.
    // A fill ends when its last return is accepted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (d_wr_req)            state_nx = WRITE;
                else if (d_req || i_req) state_nx = FILL;
            end
            FILL: begin
                if (mem_rvalid && ret == CW'(BLK_WORDS - 1)) state_nx = DONE;
            end
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Owner latch plus issue/return counters.
    // Counters restart on every IDLE cycle and saturate at BLK_WORDS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d <= 1'b0;
            iss     <= '0;
            ret     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    iss <= '0;
                    ret <= '0;
                    if (grant) owner_d <= d_wr_req | d_req;
                end
                FILL: begin
                    if (iss_open) iss <= iss + 1'b1;
                    if (mem_rvalid && ret != CW'(BLK_WORDS)) ret <= ret + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Latch address (block base for fills, exact for stores) and store data at grant.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (d_wr_req) begin
                addr_lat  <= d_addr;
                wdata_lat <= d_wdata;
            end else if (d_req) begin
                addr_lat  <= blk_base(d_addr);
            end else if (i_req) begin
                addr_lat  <= blk_base(i_addr);
            end
        end
    end

    // Output decode from state.
    // Returns are passed through combinationally only during FILL.
    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_word  = '0;
        i_fill     = 1'b0;
        d_fill     = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            FILL: begin
                i_fill = ~owner_d;
                d_fill = owner_d;
                if (iss_open) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_lat + ADDR_W'({iss[LW-1:0], 1'b0});
                end
                if (mem_rvalid) begin
                    fill_valid = 1'b1;
                    fill_word  = ret[LW-1:0];
                end
            end
            WRITE: begin
                i_fill    = ~owner_d;
                d_fill    = owner_d;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_lat;
                mem_wdata = wdata_lat;
            end
            DONE: begin
                i_fill = ~owner_d;
                d_fill = owner_d;
                i_done = ~owner_d;
                d_done = owner_d;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency pipelined read memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata;
    logic        i_fill, d_fill, fill_valid, i_done, d_done;
    logic [2:0]  fill_word;

    int          checks = 0;
    int          errors = 0;
    int          lat    = 4;
    logic        spur   = 1'b0;
    logic [15:0] pipe;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid),
        .i_fill(i_fill), .d_fill(d_fill), .fill_valid(fill_valid), .fill_word(fill_word),
        .i_done(i_done), .d_done(d_done)
    );

    always #5 clk = ~clk;

    // Memory: each read returns lat cycles after issue; reset drops in-flight reads.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[14:0], mem_en & ~mem_wr};
    end
    assign mem_rvalid = pipe[lat-1] | spur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {mem_en, mem_wr, i_fill, d_fill, fill_valid, i_done, d_done}, 0);
        check_eq({tag, "_addr"}, {mem_addr, mem_wdata}, 0);
        check_eq({tag, "_word"}, fill_word, 0);
    endtask

    // Follow one granted fill to its done pulse, checking issue order, returns and ownership.
    // Optionally raises d_req when the I fill issues its word 2.
    task automatic run_fill(input bit own_d, input logic [15:0] base, input int raise_d_at);
        int  n_iss = 0, n_ret = 0, first = -1, last = -1, w7 = -1;
        bit  got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            check_eq("own_i", i_fill, !own_d);
            check_eq("own_d", d_fill, own_d);
            if (mem_en) begin
                check_eq("rd_wr", mem_wr, 0);
                check_eq("rd_addr", mem_addr, base + 16'(2 * n_iss));
                if (n_iss == raise_d_at) begin
                    d_req  = 1'b1;
                    d_addr = 16'h500A;
                end
                if (first < 0) first = k;
                last = k;
                n_iss++;
            end
            if (fill_valid) begin
                check_eq("word", fill_word, n_ret);
                if (n_ret == 7) w7 = k;
                n_ret++;
            end
            if (i_done || d_done) begin
                check_eq("done_own", {i_done, d_done}, own_d ? 2'b01 : 2'b10);
                check_eq("done_lat", k, w7 + 1);
                check_eq("done_mem_en", mem_en, 0);
                got = 1;
                if (own_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
        end
        check_eq("timeout", got, 1);
        check_eq("first_iss", first, 0);
        check_eq("n_iss", n_iss, 8);
        check_eq("iss_span", last - first, 7);
        check_eq("n_ret", n_ret, 8);
        @(negedge clk);
        check_eq("idle_flags", {i_fill, d_fill, fill_valid}, 0);
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // I fill, latency 4, address in mid-block.
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h123A;
        run_fill(1'b0, 16'h1230, -1);

        // Simultaneous I and D miss: D wins, I follows immediately.
        i_req = 1'b1; i_addr = 16'h2010;
        d_req = 1'b1; d_addr = 16'h4002;
        run_fill(1'b1, 16'h4000, -1);
        run_fill(1'b0, 16'h2010, -1);

        // Write-through store, with a stray return that must be ignored.
        d_wr_req = 1'b1; d_addr = 16'h0106; d_wdata = 16'hBEEF;
        @(negedge clk);
        d_wr_req = 1'b0;
        spur = 1'b1;
        check_eq("wr_en", {mem_en, mem_wr}, 2'b11);
        check_eq("wr_addr", mem_addr, 16'h0106);
        check_eq("wr_data", mem_wdata, 16'hBEEF);
        check_eq("wr_flags", {d_fill, i_fill, fill_valid, d_done}, 4'b1000);
        @(negedge clk);
        spur = 1'b0;
        check_eq("wr_done", {d_done, d_fill, mem_en, fill_valid}, 4'b1100);
        @(negedge clk);
        check_idle_outputs("wr_idle");

        // D miss raised mid I fill waits for i_done.
        i_req = 1'b1; i_addr = 16'h7FF0;
        run_fill(1'b0, 16'h7FF0, 2);
        run_fill(1'b1, 16'h5000, -1);

        // Spurious returns in IDLE, then a latency-1 fill.
        lat  = 1;
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("spur_idle", {fill_valid, mem_en, i_fill, d_fill}, 0);
        end
        spur = 1'b0;
        i_req = 1'b1; i_addr = 16'h0C0F;
        run_fill(1'b0, 16'h0C00, -1);

        // Asynchronous reset at the fourth issue, then a fresh fill restarts at word 0.
        lat = 4;
        i_req = 1'b1; i_addr = 16'h3004;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 16'h3006) break;
        end
        check_eq("pre_rst_addr", mem_addr, 16'h3006);
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(negedge clk);
        check_idle_outputs("rst_hold");
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h3004;
        run_fill(1'b0, 16'h3000, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
